bht_update_sched: RTL and testbench

BHT_UPDATE_SCHED -- requirements
Module: bht_update_sched

---
 rtl/bht_update_sched.sv | 133 +++++++++++++
 tb/tb_bht_update_sched.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bht_update_sched.sv
// Resolves EX branches against the fetch prediction, raises a timed flush with redirect on mispredict,
// and queues every accepted resolution for the BHT write port, which drains it whenever bht_en allows.
module bht_update_sched #(
  parameter int QDEPTH       = 4,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc_4,
  input  logic [31:0] ex_target,
  input  logic [1:0]  ex_pred,
  input  logic [31:0] ex_pred_pc,
  input  logic        ex_taken,
  input  logic        bht_en,
  output logic        upd_en,
  output logic [31:0] upd_pc_4,
  output logic [31:0] upd_target,
  output logic [1:0]  upd_pred,
  output logic        upd_taken,
  output logic        flush,
  output logic [31:0] redirect_pc,
  output logic        q_full,
  output logic        q_overflow,
  output logic [15:0] br_cnt,
  output logic [15:0] mp_cnt
);

  localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int CW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic IDLE  = 1'b0;
  localparam logic FLUSH = 1'b1;
  localparam logic [AW:0]   QCNT  = (AW+1)'(QDEPTH);
  localparam logic [CW-1:0] FLOAD = CW'(FLUSH_CYCLES - 1);

  logic          state;
  logic [CW-1:0] fcnt;

  logic [31:0] q_pc4   [QDEPTH];
  logic [31:0] q_tgt   [QDEPTH];
  logic [1:0]  q_pred  [QDEPTH];
  logic        q_taken [QDEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;

  logic [31:0] actual_pc;
  logic        accept;
  logic        mispredict;
  logic        empty;
  logic        full;
  logic        pop;
  logic        push;

  assign actual_pc  = ex_taken ? ex_target : ex_pc_4;
  assign accept     = ex_valid && (state == IDLE);
  assign mispredict = accept && (actual_pc != ex_pred_pc);

  assign empty = (count == '0);
  assign full  = (count == QCNT);
  assign pop   = bht_en && !empty;
  // A pop in the same cycle frees the head slot, so a full queue can still take the push.
  assign push  = accept && (!full || pop);

  assign upd_en     = pop;
  assign upd_pc_4   = q_pc4[rd_ptr];
  assign upd_target = q_tgt[rd_ptr];
  assign upd_pred   = q_pred[rd_ptr];
  assign upd_taken  = q_taken[rd_ptr];

  assign flush  = (state == FLUSH);
  assign q_full = full;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      fcnt        <= '0;
      redirect_pc <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mispredict) begin
            state       <= FLUSH;
            fcnt        <= FLOAD;
            redirect_pc <= actual_pc;
          end
        end
        default: begin
          if (fcnt == '0) state <= IDLE;
          else            fcnt  <= fcnt - CW'(1);
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      q_pc4[wr_ptr]   <= ex_pc_4;
      q_tgt[wr_ptr]   <= ex_target;
      q_pred[wr_ptr]  <= ex_pred;
      q_taken[wr_ptr] <= ex_taken;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      q_overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      if (accept && !push) q_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt <= '0;
      mp_cnt <= '0;
    end else begin
      if (accept && br_cnt != 16'hFFFF)     br_cnt <= br_cnt + 16'd1;
      if (mispredict && mp_cnt != 16'hFFFF) mp_cnt <= mp_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_bht_update_sched.sv
// Random and directed stimulus for bht_update_sched, checked every cycle against a queue-based reference model.
module tb_bht_update_sched;

  localparam int QDEPTH       = 4;
  localparam int FLUSH_CYCLES = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_pc_4 = '0;
  logic [31:0] ex_target = '0;
  logic [1:0]  ex_pred = '0;
  logic [31:0] ex_pred_pc = '0;
  logic        ex_taken = 1'b0;
  logic        bht_en = 1'b0;
  logic        upd_en;
  logic [31:0] upd_pc_4;
  logic [31:0] upd_target;
  logic [1:0]  upd_pred;
  logic        upd_taken;
  logic        flush;
  logic [31:0] redirect_pc;
  logic        q_full;
  logic        q_overflow;
  logic [15:0] br_cnt;
  logic [15:0] mp_cnt;

  bht_update_sched #(.QDEPTH(QDEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_pc_4(ex_pc_4), .ex_target(ex_target), .ex_pred(ex_pred),
    .ex_pred_pc(ex_pred_pc), .ex_taken(ex_taken), .bht_en(bht_en),
    .upd_en(upd_en), .upd_pc_4(upd_pc_4), .upd_target(upd_target), .upd_pred(upd_pred),
    .upd_taken(upd_taken), .flush(flush), .redirect_pc(redirect_pc), .q_full(q_full),
    .q_overflow(q_overflow), .br_cnt(br_cnt), .mp_cnt(mp_cnt)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  // Reference model: flush as a remaining-cycle count, queue as a plain SV queue.
  typedef struct packed {
    logic [31:0] pc4;
    logic [31:0] tgt;
    logic [1:0]  pr;
    logic        tk;
  } ent_t;

  ent_t        mq[$];
  int          m_flush_left = 0;
  logic [31:0] m_redir = '0;
  logic        m_ovf = 1'b0;
  int          m_br = 0;
  int          m_mp = 0;

  always @(negedge clk) begin
    logic        exp_upd;
    logic        acc;
    logic        mis;
    logic [31:0] act_pc;
    if (!rst_n) begin
      mq.delete();
      m_flush_left = 0;
      m_redir = '0;
      m_ovf = 1'b0;
      m_br = 0;
      m_mp = 0;
      chk("rst_flush", {31'd0, flush}, 32'd0);
      chk("rst_upd_en", {31'd0, upd_en}, 32'd0);
      chk("rst_q_full", {31'd0, q_full}, 32'd0);
      chk("rst_ovf", {31'd0, q_overflow}, 32'd0);
      chk("rst_redirect", redirect_pc, 32'd0);
      chk("rst_br_cnt", {16'd0, br_cnt}, 32'd0);
      chk("rst_mp_cnt", {16'd0, mp_cnt}, 32'd0);
    end else begin
      exp_upd = bht_en && (mq.size() > 0);
      chk("flush", {31'd0, flush}, {31'd0, m_flush_left > 0});
      chk("redirect_pc", redirect_pc, m_redir);
      chk("upd_en", {31'd0, upd_en}, {31'd0, exp_upd});
      if (exp_upd) begin
        chk("upd_pc_4", upd_pc_4, mq[0].pc4);
        chk("upd_target", upd_target, mq[0].tgt);
        chk("upd_pred", {30'd0, upd_pred}, {30'd0, mq[0].pr});
        chk("upd_taken", {31'd0, upd_taken}, {31'd0, mq[0].tk});
      end
      chk("q_full", {31'd0, q_full}, {31'd0, mq.size() == QDEPTH});
      chk("q_overflow", {31'd0, q_overflow}, {31'd0, m_ovf});
      chk("br_cnt", {16'd0, br_cnt}, m_br);
      chk("mp_cnt", {16'd0, mp_cnt}, m_mp);

      acc    = ex_valid && (m_flush_left == 0);
      act_pc = ex_taken ? ex_target : ex_pc_4;
      mis    = acc && (act_pc != ex_pred_pc);
      if (m_flush_left > 0) m_flush_left--;
      if (mis) begin
        m_flush_left = FLUSH_CYCLES;
        m_redir = act_pc;
      end
      if (exp_upd) void'(mq.pop_front());
      if (acc) begin
        if (mq.size() < QDEPTH) mq.push_back('{pc4: ex_pc_4, tgt: ex_target, pr: ex_pred, tk: ex_taken});
        else m_ovf = 1'b1;
      end
      if (acc && m_br < 65535) m_br++;
      if (mis && m_mp < 65535) m_mp++;
    end
  end

  task automatic drive(input logic v, input logic [31:0] pc4, input logic [31:0] tgt,
                       input logic [1:0] pr, input logic [31:0] ppc, input logic tk, input logic be);
    @(posedge clk); #1;
    ex_valid = v; ex_pc_4 = pc4; ex_target = tgt; ex_pred = pr;
    ex_pred_pc = ppc; ex_taken = tk; bht_en = be;
  endtask

  task automatic acc_ok(input logic [31:0] tgt, input logic be);
    drive(1'b1, 32'h0000_1000, tgt, 2'b11, tgt, 1'b1, be);
  endtask

  task automatic idle(input logic be);
    drive(1'b0, 32'h0, 32'h0, 2'b00, 32'h0, 1'b0, be);
  endtask

  task automatic settle();
    @(negedge clk); #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0; ex_valid = 1'b0; bht_en = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] r_pc4, r_tgt, r_act;
    logic        r_tk;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Correct taken prediction, no bypass, drains next cycle.
    drive(1'b1, 32'h14, 32'h40, 2'b10, 32'h40, 1'b1, 1'b1);
    settle();
    chk("t1_no_flush", {31'd0, flush}, 32'd0);
    chk("t1_no_bypass", {31'd0, upd_en}, 32'd0);
    idle(1'b1);
    settle();
    chk("t1_upd_en", {31'd0, upd_en}, 32'd1);
    chk("t1_upd_target", upd_target, 32'h40);
    chk("t1_upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("t1_br_cnt", {16'd0, br_cnt}, 32'd1);
    chk("t1_mp_cnt", {16'd0, mp_cnt}, 32'd0);

    // Not-taken mispredict; wrong-path valids during flush are ignored.
    drive(1'b1, 32'h1C, 32'h200, 2'b01, 32'h80, 1'b0, 1'b1);
    settle();
    chk("t2_flush_n", {31'd0, flush}, 32'd0);
    drive(1'b1, 32'h24, 32'h300, 2'b01, 32'h0, 1'b1, 1'b1);
    settle();
    chk("t2_flush_n1", {31'd0, flush}, 32'd1);
    chk("t2_redirect", redirect_pc, 32'h1C);
    chk("t2_mp_cnt", {16'd0, mp_cnt}, 32'd1);
    drive(1'b1, 32'h28, 32'h300, 2'b01, 32'h0, 1'b1, 1'b1);
    settle();
    chk("t2_flush_n2", {31'd0, flush}, 32'd1);
    idle(1'b1);
    settle();
    chk("t2_flush_n3", {31'd0, flush}, 32'd0);
    chk("t2_br_cnt", {16'd0, br_cnt}, 32'd2);
    chk("t2_mp_cnt_end", {16'd0, mp_cnt}, 32'd1);
    chk("t2_redirect_hold", redirect_pc, 32'h1C);

    // Fill with the write port blocked, overflow on the fifth, then drain in order.
    for (int i = 0; i < 5; i++) acc_ok(32'h100 + 32'(i) * 4, 1'b0);
    settle();
    chk("t3_full", {31'd0, q_full}, 32'd1);
    chk("t3_ovf_not_yet", {31'd0, q_overflow}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      idle(1'b1);
      settle();
      chk("t3_drain_en", {31'd0, upd_en}, 32'd1);
      chk("t3_drain_tgt", upd_target, 32'h100 + 32'(i) * 4);
      chk("t3_ovf", {31'd0, q_overflow}, 32'd1);
    end
    idle(1'b1);
    settle();
    chk("t3_drained", {31'd0, upd_en}, 32'd0);

    // Push and pop together while full.
    do_reset();
    for (int i = 0; i < 4; i++) acc_ok(32'h300 + 32'(i) * 4, 1'b0);
    acc_ok(32'h340, 1'b1);
    settle();
    chk("t4_full_before", {31'd0, q_full}, 32'd1);
    chk("t4_head", upd_target, 32'h300);
    idle(1'b0);
    settle();
    chk("t4_still_full", {31'd0, q_full}, 32'd1);
    chk("t4_no_ovf", {31'd0, q_overflow}, 32'd0);
    idle(1'b1);
    settle();
    chk("t4_head_adv", upd_target, 32'h304);

    // Reset while flushing with two entries queued.
    do_reset();
    acc_ok(32'h500, 1'b0);
    drive(1'b1, 32'h60, 32'h700, 2'b00, 32'h60, 1'b1, 1'b0);
    idle(1'b0);
    settle();
    chk("t5_flushing", {31'd0, flush}, 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0; bht_en = 1'b1;
    #1;
    chk("t5_flush_rst", {31'd0, flush}, 32'd0);
    chk("t5_upd_rst", {31'd0, upd_en}, 32'd0);
    chk("t5_br_rst", {16'd0, br_cnt}, 32'd0);
    chk("t5_mp_rst", {16'd0, mp_cnt}, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1; bht_en = 1'b0;

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        r_pc4 = $urandom & 32'hFFFF_FFFC;
        r_tgt = $urandom & 32'hFFFF_FFFC;
        r_tk  = 1'($urandom);
        r_act = r_tk ? r_tgt : r_pc4;
        drive(1'($urandom_range(0, 3) != 0), r_pc4, r_tgt, 2'($urandom),
              ($urandom_range(0, 2) == 0) ? (r_act ^ 32'h4) : r_act, r_tk,
              1'($urandom_range(0, 2) != 0));
      end
    end

    // Saturation of the branch counter.
    do_reset();
    for (int n = 0; n < 65540; n++) acc_ok(32'h800, 1'b1);
    settle();
    chk("t6_br_sat", {16'd0, br_cnt}, 32'h0000_FFFF);
    chk("t6_mp_zero", {16'd0, mp_cnt}, 32'd0);
    idle(1'b1);
    settle();
    chk("t6_br_sat_hold", {16'd0, br_cnt}, 32'h0000_FFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
